// File: rtl/mux_arb_2to1_pkg.sv
// mux_arb_2to1_pkg
// Source encoding shared by the arbiter, its interface users and anything that
// follows out_sel. The encoding matches the 2:1 mux select: 1 passes A, 0 passes B.
// No ports; contents are one enum and one helper function.
package mux_arb_2to1_pkg;

   typedef enum logic {
      SRC_B = 1'b0,
      SRC_A = 1'b1
   } src_e;

   // The requester that is not 's'.
   function automatic src_e other_src(input src_e s);
      return (s == SRC_A) ? SRC_B : SRC_A;
   endfunction

endpackage

// File: rtl/mux_arb_2to1_if.sv
// mux_arb_2to1_if
// Bundles the two requester channels and the downstream channel of the 2:1
// arbiter.
//   a_valid/a_data/a_ready : requester A handshake and payload
//   b_valid/b_data/b_ready : requester B handshake and payload
//   out_valid/out_data/out_sel/out_ready : registered downstream channel
// The master modport is the side that owns the requesters and the downstream
// sink. The slave modport is the arbiter.
interface mux_arb_2to1_if #(
   parameter int D = 8
);

   logic         a_valid;
   logic [D-1:0] a_data;
   logic         a_ready;
   logic         b_valid;
   logic [D-1:0] b_data;
   logic         b_ready;
   logic         out_valid;
   logic [D-1:0] out_data;
   logic         out_sel;
   logic         out_ready;

   modport master (
      output a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/mux_1to1_out_reg.sv
// mux_1to1_out_reg
// Load-enabled output register for the arbiter. It holds a payload of W bits
// (select bit plus data) and a valid flag. Reset is asynchronous and active-low.
//   clk, rst_n : clock, async active-low reset
//   load_en    : the slot is empty or is being drained this cycle
//   take       : a beat is accepted this cycle (only meaningful with load_en)
//   d          : payload to capture on take
//   valid, q   : registered valid flag and payload
module mux_1to1_out_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_en,
   input  logic         take,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   // On a load cycle the valid flag follows the accept. The payload changes
   // only on a real accept, so an idle load cycle leaves the last beat visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load_en) begin
         valid <= take;
         if (take) begin
            q <= d;
         end
      end
   end

endmodule

// File: rtl/mux_arb_2to1.sv
// mux_arb_2to1
// Shares one D-bit downstream channel between requesters A and B. It uses
// round-robin arbitration with a bounded burst lock: the owner may keep winning
// up to BURST consecutive beats while the other side waits. Accepted beats pass
// through a one-deep registered output stage. out_sel reports which source each
// beat came from (1=A, 0=B).
//   clk, rst_n : clock, async active-low reset
//   bus        : requester and downstream handshakes (slave modport)
// Parameters: D data width, BURST burst limit (1..255), CW counter width
// (2**CW > BURST).
module mux_arb_2to1
   import mux_arb_2to1_pkg::*;
#(
   parameter int D     = 8,
   parameter int BURST = 4,
   parameter int CW    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mux_arb_2to1_if.slave       bus
);

   localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

   src_e         owner;
   src_e         grant_src;
   logic         owner_live;
   logic [CW-1:0] beat_cnt;

   logic         load_en;
   logic         owner_valid;
   logic         other_valid;
   logic         keep_owner;
   logic         grant_valid;
   logic         accept;
   logic [D-1:0] grant_data;
   logic         out_valid_q;
   logic [D:0]   out_q;

   assign load_en = !out_valid_q | bus.out_ready;

   // Grant selection. owner_live stays clear until the first beat after
   // reset. While it is clear, the reset owner (B) cannot claim a burst, so A
   // wins a simultaneous first request.
   always_comb begin
      owner_valid = (owner == SRC_A) ? bus.a_valid : bus.b_valid;
      other_valid = (owner == SRC_A) ? bus.b_valid : bus.a_valid;
      keep_owner  = owner_live & owner_valid &
                    (!other_valid | (beat_cnt < CNT_MAX));
      grant_valid = 1'b0;
      grant_src   = owner;
      if (keep_owner) begin
         grant_valid = 1'b1;
         grant_src   = owner;
      end else if (other_valid) begin
         grant_valid = 1'b1;
         grant_src   = other_src(owner);
      end else if (owner_valid) begin
         grant_valid = 1'b1;
         grant_src   = owner;
      end
   end

   // rst_n gates the readies so that nothing handshakes while reset is held.
   assign accept      = rst_n & load_en & grant_valid;
   assign bus.a_ready = accept & (grant_src == SRC_A);
   assign bus.b_ready = accept & (grant_src == SRC_B);
   assign grant_data  = (grant_src == SRC_A) ? bus.a_data : bus.b_data;

   // Owner and burst counter move only on accepted beats. Holding the counter
   // at BURST-1 means a long solo run yields at once when the other side shows up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= SRC_B;
         owner_live <= 1'b0;
         beat_cnt   <= '0;
      end else if (accept) begin
         owner_live <= 1'b1;
         if (grant_src == owner) begin
            if (beat_cnt != CNT_MAX) begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end else begin
            owner    <= grant_src;
            beat_cnt <= '0;
         end
      end
   end

   mux_1to1_out_reg #(
      .W (D + 1)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (load_en),
      .take    (accept),
      .d       ({logic'(grant_src), grant_data}),
      .valid   (out_valid_q),
      .q       (out_q)
   );

   assign bus.out_valid = out_valid_q;
   assign bus.out_sel   = out_q[D];
   assign bus.out_data  = out_q[D-1:0];

endmodule

// File: tb/tb_mux_arb_2to1.sv
// tb_mux_arb_2to1
// Directed bench for mux_arb_2to1 with BURST=4. Stimulus pushes the expected
// {sel,data} of each beat it expects to be accepted into a queue. A monitor
// pops an entry and compares it whenever the DUT presents a beat that is being
// drained.
module tb_mux_arb_2to1;

   localparam int D = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mux_arb_2to1_if #(.D(D)) bus ();

   mux_arb_2to1 #(
      .D     (D),
      .BURST (4),
      .CW    (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [D:0] exp_q[$];
   logic [D:0] mon_exp;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic push(input logic sel, input logic [D-1:0] data);
      exp_q.push_back({sel, data});
   endtask

   // Drives one cycle of inputs from just after a rising edge. It checks the
   // combinational readies and, where requested (>= 0), out_valid and out_data
   // at the falling edge. It returns just after the next rising edge.
   task automatic apply_stimulus(input logic av, input logic [D-1:0] ad,
                                 input logic bv, input logic [D-1:0] bd,
                                 input logic ordy,
                                 input logic exp_ar, input logic exp_br,
                                 input int exp_ov, input int exp_od);
      bus.a_valid   = av;
      bus.a_data    = ad;
      bus.b_valid   = bv;
      bus.b_data    = bd;
      bus.out_ready = ordy;
      @(negedge clk);
      check_output("a_ready", 32'(bus.a_ready), 32'(exp_ar));
      check_output("b_ready", 32'(bus.b_ready), 32'(exp_br));
      if (exp_ov >= 0) check_output("out_valid", 32'(bus.out_valid), exp_ov);
      if (exp_od >= 0) check_output("out_data", 32'(bus.out_data), exp_od);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      rst_n       = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: a drained beat must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat: got sel=%0d data=0x%0h, expected no beat",
                     bus.out_sel, bus.out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("beat", 32'({bus.out_sel, bus.out_data}), 32'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Hand-computed contention pattern: A0..A3, B0..B3, A4, A5.
   localparam logic [9:0] CONT_A = 10'b11_0000_1111;

   // Owner-drops-early pattern, one entry per cycle.
   logic [6:0]   od_av = 7'b1111011;
   logic [6:0]   od_ar = 7'b1000011;
   logic [6:0]   od_br = 7'b0111100;
   logic [D-1:0] od_ad [7] = '{8'h51, 8'h52, 8'h00, 8'h53, 8'h53, 8'h53, 8'h53};
   logic [D-1:0] od_bd [7] = '{8'h61, 8'h61, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

   initial begin
      int na;
      int nb;
      logic exp_a;
      logic [9:0] cont_a;

      bus.a_valid   = 1'b1;
      bus.a_data    = 8'hAA;
      bus.b_valid   = 1'b1;
      bus.b_data    = 8'hBB;
      bus.out_ready = 1'b1;
      cont_a        = CONT_A;
      @(posedge clk);
      #1;

      // Reset held with both requesters valid: no readies, outputs cleared.
      $display("[TB] reset and idle");
      for (int i = 0; i < 3; i++) apply_stimulus(1, 8'hAA, 1, 8'hBB, 1, 0, 0, 0, 0);
      check_output("reset out_sel", 32'(bus.out_sel), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);

      // A alone, back to back.
      $display("[TB] single requester");
      push(1'b1, 8'h11);
      apply_stimulus(1, 8'h11, 0, 8'h00, 1, 1, 0, 0, -1);
      push(1'b1, 8'h22);
      apply_stimulus(1, 8'h22, 0, 8'h00, 1, 1, 0, 1, 8'h11);
      push(1'b1, 8'h33);
      apply_stimulus(1, 8'h33, 0, 8'h00, 1, 1, 0, 1, 8'h22);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h33);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h33);

      // Both valid from reset: A wins first, then bursts of 4 alternate.
      $display("[TB] contention");
      do_reset();
      na = 0;
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         exp_a = cont_a[i];
         if (exp_a) push(1'b1, 8'(8'hA0 + na));
         else       push(1'b0, 8'(8'hB0 + nb));
         apply_stimulus(1, 8'(8'hA0 + na), 1, 8'(8'hB0 + nb), 1, exp_a, !exp_a, -1, -1);
         if (exp_a) na++;
         else       nb++;
      end
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, -1, -1);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, -1);

      // Backpressure: beat 0x22 held while out_ready is low.
      $display("[TB] backpressure");
      push(1'b1, 8'h22);
      apply_stimulus(1, 8'h22, 0, 8'h00, 1, 1, 0, 0, -1);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 8'h44, 1, 8'h99, 0, 0, 0, 1, 8'h22);
      push(1'b1, 8'h44);
      apply_stimulus(1, 8'h44, 1, 8'h99, 1, 1, 0, 1, 8'h22);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h44);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, -1);

      // A drops after 2 beats. B takes over with a fresh count and keeps 4 beats.
      $display("[TB] owner drops early");
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (od_ar[i]) push(1'b1, od_ad[i]);
         else          push(1'b0, od_bd[i]);
         apply_stimulus(od_av[i], od_ad[i], 1, od_bd[i], 1, od_ar[i], od_br[i], -1, -1);
      end
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, -1, -1);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, -1);

      // Async reset between edges while a beat sits in the output register.
      $display("[TB] async reset mid-burst");
      push(1'b1, 8'h71);
      apply_stimulus(1, 8'h71, 1, 8'h81, 1, 1, 0, -1, -1);
      check_output("pre-reset out_valid", 32'(bus.out_valid), 1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("async out_valid", 32'(bus.out_valid), 0);
      check_output("async out_data", 32'(bus.out_data), 0);
      check_output("async a_ready", 32'(bus.a_ready), 0);
      @(posedge clk);
      #1;
      apply_stimulus(1, 8'h72, 1, 8'h82, 1, 0, 0, 0, 0);
      rst_n = 1'b1;
      push(1'b1, 8'h72);
      apply_stimulus(1, 8'h72, 1, 8'h82, 1, 1, 0, 0, -1);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h72);
      apply_stimulus(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, -1);

      check_output("scoreboard empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
